load_store_unit_mips: RTL
=========================

# load_store_unit_mips

Multi-cycle load/store unit between the MIPS datapath and the word-organised data memory. It accepts one load or store request per transaction and checks alignment. It drives the word-wide memory port, sign- or zero-extending sub-word loads. Byte and halfword stores are done as a read-modify-write so the memory keeps its single full-word write port.

## Interface
- n_bit, 31, MSB index of data/address buses (32-bit datapath)
- in_clk  input  1  clock, all state updates on rising edge
- in_reset  input  1  synchronous, active-high reset
- in_req  input  1  request strobe; sampled only in IDLE
- in_op  input  4  operation: 0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW; all others illegal
- in_addr  input  n_bit+1  byte address
- in_wdata  input  n_bit+1  store data; SB uses [7:0], SH uses [15:0]
- out_rdata  output  n_bit+1  extended load result, registered
- out_busy  output  1  high whenever state is not IDLE
- out_done  output  1  one-cycle completion pulse
- out_error  output  1  valid with out_done; misaligned address or illegal op
- out_mem_we  output  1  memory write enable
- out_mem_addr  output  n_bit+1  word address = {2'b00, addr[31:2]}
- out_mem_wdata  output  n_bit+1  full word to write
- in_mem_rdata  input  n_bit+1  combinational memory read data for out_mem_addr

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: when in_req=1, latch op, addr and wdata.
  - Illegal op, LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]≠0 -> DONE with the error flag set. No memory access; out_rdata unchanged.
  - Load or SB/SH -> READ.
  - SW -> WRITE.
- READ: out_mem_addr driven from the latched address.
  - Load: select lane, extend, register into out_rdata -> DONE.
  - SB/SH: capture in_mem_rdata into the merge register -> WRITE.
- WRITE: out_mem_we=1.
  - SW: out_mem_wdata = latched wdata.
  - SB/SH: captured word with the target byte/halfword lane replaced.
  - -> DONE.
- DONE: out_done=1, out_error valid -> IDLE.
- Lane mapping (little-endian default): byte k = bits [8k+7:8k], k = addr[1:0]; halfword h = bits [16h+15:16h], h = addr[1].
- Extension: LB/LH replicate the lane MSB; LBU/LHU zero-fill.
- in_req outside IDLE is ignored; there is no queueing.
- out_mem_addr holds the latched word address in READ, WRITE and DONE, and is 0 in IDLE. out_mem_wdata is 0 unless in WRITE.
- The address range is not checked here; the memory owns its depth (2048 words).

## Timing
- Reset values: state IDLE, out_rdata 0, out_busy 0, out_done 0, out_error 0, out_mem_we 0, out_mem_addr 0, out_mem_wdata 0.
- Request sampled at edge E0. Latencies to the out_done pulse:
  - Loads: READ during E0–E1, done during E1–E2 (done two cycles after acceptance).
  - SW: WRITE in cycle 1, DONE in cycle 2.
  - SB/SH: READ, WRITE, DONE (three cycles).
  - Error: DONE in cycle 1.
- out_rdata is valid from the DONE cycle and holds until the next successful load.
- out_mem_we is decoded from registered state: at most one write strobe per store, never for loads or errors.
- Reset mid-operation: at the edge sampling in_reset=1, the FSM returns to IDLE and every output goes to its reset value.
  - A pending SB/SH merge is discarded and out_done does not pulse.
  - A WRITE cycle coinciding with reset is cleared by the memory's shared reset.
- The minimum request spacing is the latency plus one IDLE cycle.

## Configuration
- LSU_BIG_ENDIAN_EN defined: big-endian lanes.
  - Byte k = bits [31-8k:24-8k].
  - Halfword h = bits [31-16h:16-16h].
  - Alignment rules and timing are unchanged.
- Undefined: little-endian mapping as in Operation.

## Test plan
- Memory word 2 = 0x8899AABB (little-endian).
  - LB addr 9 -> out_rdata 0xFFFFFFAA.
  - LBU addr 9 -> 0x000000AA.
  - Each out_done follows acceptance by 2 cycles.
- LH addr 10 -> 0xFFFF8899; LHU addr 8 -> 0x0000AABB; LW addr 8 -> 0x8899AABB.
- SB addr 9, wdata 0x12345611 -> exactly one we pulse, word 2 = 0x889911BB, done 3 cycles after acceptance. Then SH addr 10, wdata 0x0000CAFE -> word 2 = 0xCAFE11BB.
- SW addr 6 and LH addr 9 -> out_error=1 with done one cycle after acceptance, no we pulse, memory and out_rdata unchanged. Op 0011 gives the same result.
- Assert in_reset during the READ cycle of SB addr 9 -> no we, no done, busy low after that edge. Word 2 unaffected by the LSU (cleared only by the memory reset).
- With LSU_BIG_ENDIAN_EN and word 2 = 0x8899AABB: LB addr 9 -> 0xFFFFFF99; SB addr 8, wdata 0x11 -> word 2 = 0x1199AABB.

Source files
------------

// File: rtl/load_store_unit_mips_if.sv
// Datapath/memory-side bus of the MIPS load/store unit.
// master: datapath and memory model; slave: the LSU.
interface load_store_unit_mips_if #(
    parameter int unsigned n_bit = 31
);
    logic             in_req;
    logic [3:0]       in_op;
    logic [n_bit:0]   in_addr;
    logic [n_bit:0]   in_wdata;
    logic [n_bit:0]   out_rdata;
    logic             out_busy;
    logic             out_done;
    logic             out_error;
    logic             out_mem_we;
    logic [n_bit:0]   out_mem_addr;
    logic [n_bit:0]   out_mem_wdata;
    logic [n_bit:0]   in_mem_rdata;

    modport master (
        output in_req, in_op, in_addr, in_wdata, in_mem_rdata,
        input  out_rdata, out_busy, out_done, out_error,
               out_mem_we, out_mem_addr, out_mem_wdata
    );

    modport slave (
        input  in_req, in_op, in_addr, in_wdata, in_mem_rdata,
        output out_rdata, out_busy, out_done, out_error,
               out_mem_we, out_mem_addr, out_mem_wdata
    );
endinterface

// File: rtl/load_store_unit_mips.sv
// Multi-cycle MIPS load/store unit with alignment check and read-modify-write sub-word stores.
// Define LSU_BIG_ENDIAN_EN for big-endian lane mapping; little-endian otherwise.
module load_store_unit_mips #(
    parameter int unsigned n_bit = 31
) (
    input logic                   in_clk,
    input logic                   in_reset,
    load_store_unit_mips_if.slave lsu
);
    localparam int unsigned DW = n_bit + 1;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_WRITE = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [DW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   st_data_q, st_data_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            mem_we_q, mem_we_d;
    logic [DW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

    // Illegal opcode or address misaligned for the access size.
    function automatic logic op_illegal(input logic [3:0] op, input logic [1:0] a);
        case (op)
            4'b0000, 4'b0100, 4'b1000: op_illegal = 1'b0;
            4'b0001, 4'b0101, 4'b1001: op_illegal = a[0];
            4'b0010, 4'b1010:          op_illegal = |a;
            default:                   op_illegal = 1'b1;
        endcase
    endfunction

    // Bit offset of the selected byte/halfword lane within the word.
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] a);
`ifdef LSU_BIG_ENDIAN_EN
        lane_shift = (size == SZ_B) ? {~a, 3'b000} : {~a[1], 4'b0000};
`else
        lane_shift = (size == SZ_B) ? {a, 3'b000} : {a[1], 4'b0000};
`endif
    endfunction

    function automatic logic [DW-1:0] load_extend(input logic [3:0] op,
                                                  input logic [DW-1:0] word,
                                                  input logic [1:0] a);
        logic [DW-1:0] shifted;
        logic [7:0]    b;
        logic [15:0]   h;
        shifted = word >> lane_shift(op[1:0], a);
        b       = shifted[7:0];
        h       = shifted[15:0];
        case (op[1:0])
            SZ_B:    load_extend = {{(DW-8){b[7] & ~op[2]}}, b};
            SZ_H:    load_extend = {{(DW-16){h[15] & ~op[2]}}, h};
            default: load_extend = word;
        endcase
    endfunction

    function automatic logic [DW-1:0] store_merge(input logic [1:0] size,
                                                  input logic [DW-1:0] word,
                                                  input logic [DW-1:0] data,
                                                  input logic [1:0] a);
        logic [DW-1:0] mask;
        logic [4:0]    sh;
        mask        = (size == SZ_B) ? DW'(8'hFF) : DW'(16'hFFFF);
        sh          = lane_shift(size, a);
        store_merge = (word & ~(mask << sh)) | ((data & mask) << sh);
    endfunction

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q     <= S_IDLE;
            op_q        <= 4'b0000;
            addr_q      <= '0;
            st_data_q   <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            st_data_q   <= st_data_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next state; every output register is loaded with its value for the next state.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        st_data_d   = st_data_q;
        rdata_d     = rdata_q;
        error_d     = 1'b0;
        mem_wdata_d = '0;

        case (state_q)
            S_IDLE: begin
                if (lsu.in_req) begin
                    op_d      = lsu.in_op;
                    addr_d    = lsu.in_addr;
                    st_data_d = lsu.in_wdata;
                    if (op_illegal(lsu.in_op, lsu.in_addr[1:0])) begin
                        state_d = S_DONE;
                        error_d = 1'b1;
                    end else if (lsu.in_op == 4'b1010) begin
                        state_d     = S_WRITE;
                        mem_wdata_d = lsu.in_wdata;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (op_q[3]) begin
                    state_d     = S_WRITE;
                    mem_wdata_d = store_merge(op_q[1:0], lsu.in_mem_rdata, st_data_q, addr_q[1:0]);
                end else begin
                    state_d = S_DONE;
                    rdata_d = load_extend(op_q, lsu.in_mem_rdata, addr_q[1:0]);
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        mem_we_d   = (state_d == S_WRITE);
        mem_addr_d = (state_d == S_IDLE) ? '0 : {2'b00, addr_d[DW-1:2]};
    end

    assign lsu.out_rdata     = rdata_q;
    assign lsu.out_busy      = busy_q;
    assign lsu.out_done      = done_q;
    assign lsu.out_error     = error_q;
    assign lsu.out_mem_we    = mem_we_q;
    assign lsu.out_mem_addr  = mem_addr_q;
    assign lsu.out_mem_wdata = mem_wdata_q;
endmodule
